// File: rtl/spi_master.sv
// Single-byte full-duplex SPI master, MSB first, modes 0..3.
// Chip-select and byte framing are left to the sequencer above this engine.
module spi_master #(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_SPI_Clk,
  input  logic       i_SPI_MISO,
  output logic       o_SPI_MOSI
);

  localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);
  localparam int   CW   = $clog2(CLKS_PER_HALF_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_HALF_BIT - 1);

  typedef enum logic {
    ST_IDLE,
    ST_XFER
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] half_cnt;
  logic [4:0]    edge_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shadow;
  logic [7:0]    rx_shift;
  logic          first_bit;

  logic start;
  logic finish;
  logic tick;
  logic leading;
  logic trailing;
  logic drive_bit;
  logic sample_bit;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // edge_cnt holds the edges still to come, so edge k sees 17-k:
  // an even remaining count marks a leading edge, an odd one a trailing edge.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    finish     = 1'b0;
    tick       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_TX_DV) begin
          start      = 1'b1;
          next_state = ST_XFER;
        end
      end
      ST_XFER: begin
        if (edge_cnt == 5'd0) begin
          finish     = 1'b1;
          next_state = ST_IDLE;
        end else if (half_cnt == HALF_LAST) begin
          tick = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    leading    = tick & ~edge_cnt[0];
    trailing   = tick & edge_cnt[0];
    drive_bit  = CPHA ? leading : (first_bit | (trailing & (edge_cnt != 5'd1)));
    sample_bit = CPHA ? trailing : leading;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_TX_Ready <= 1'b1;
      o_RX_DV    <= 1'b0;
      o_RX_Byte  <= 8'h00;
      o_SPI_Clk  <= CPOL;
      o_SPI_MOSI <= 1'b0;
      half_cnt   <= '0;
      edge_cnt   <= 5'd0;
      tx_bit     <= 3'd0;
      tx_shadow  <= 8'h00;
      rx_shift   <= 8'h00;
      first_bit  <= 1'b0;
    end else begin
      o_RX_DV   <= finish;
      first_bit <= start;
      if (start) begin
        tx_shadow  <= i_TX_Byte;
        o_TX_Ready <= 1'b0;
        edge_cnt   <= 5'd16;
        half_cnt   <= '0;
        tx_bit     <= 3'd7;
      end
      if (finish) begin
        o_TX_Ready <= 1'b1;
        o_RX_Byte  <= rx_shift;
      end
      if (state == ST_XFER && edge_cnt != 5'd0) begin
        half_cnt <= tick ? '0 : half_cnt + CW'(1);
      end
      if (tick) begin
        o_SPI_Clk <= ~o_SPI_Clk;
        edge_cnt  <= edge_cnt - 5'd1;
      end
      if (drive_bit) begin
        o_SPI_MOSI <= tx_shadow[tx_bit];
        tx_bit     <= tx_bit - 3'd1;
      end
      // MISO is taken on the same clock that moves SCLK to its sampling level.
      if (sample_bit) begin
        rx_shift <= {rx_shift[6:0], i_SPI_MISO};
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: one instance per SPI mode, table vectors, random
// transfers and hand-built sequences for ignored start, back-to-back and reset.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst        [4];
  logic       dv         [4];
  logic [7:0] tx_byte    [4];
  logic       ready      [4];
  logic       rx_dv      [4];
  logic [7:0] rx_byte    [4];
  logic       sclk       [4];
  logic       mosi       [4];
  logic       miso       [4];
  logic       loop_en    [4];
  logic       slave_miso [4];

  int n_vec  = 0;
  int n_miss = 0;

  for (genvar g = 0; g < 4; g++) begin : g_miso
    assign miso[g] = loop_en[g] ? mosi[g] : slave_miso[g];
  end

  spi_master #(.SPI_MODE(0), .CLKS_PER_HALF_BIT(3)) u_mode0 (
    .i_Clk(clk), .i_Rst(rst[0]), .i_TX_Byte(tx_byte[0]), .i_TX_DV(dv[0]),
    .o_TX_Ready(ready[0]), .o_RX_DV(rx_dv[0]), .o_RX_Byte(rx_byte[0]),
    .o_SPI_Clk(sclk[0]), .i_SPI_MISO(miso[0]), .o_SPI_MOSI(mosi[0]));

  spi_master #(.SPI_MODE(1), .CLKS_PER_HALF_BIT(2)) u_mode1 (
    .i_Clk(clk), .i_Rst(rst[1]), .i_TX_Byte(tx_byte[1]), .i_TX_DV(dv[1]),
    .o_TX_Ready(ready[1]), .o_RX_DV(rx_dv[1]), .o_RX_Byte(rx_byte[1]),
    .o_SPI_Clk(sclk[1]), .i_SPI_MISO(miso[1]), .o_SPI_MOSI(mosi[1]));

  spi_master #(.SPI_MODE(2), .CLKS_PER_HALF_BIT(2)) u_mode2 (
    .i_Clk(clk), .i_Rst(rst[2]), .i_TX_Byte(tx_byte[2]), .i_TX_DV(dv[2]),
    .o_TX_Ready(ready[2]), .o_RX_DV(rx_dv[2]), .o_RX_Byte(rx_byte[2]),
    .o_SPI_Clk(sclk[2]), .i_SPI_MISO(miso[2]), .o_SPI_MOSI(mosi[2]));

  spi_master #(.SPI_MODE(3), .CLKS_PER_HALF_BIT(4)) u_mode3 (
    .i_Clk(clk), .i_Rst(rst[3]), .i_TX_Byte(tx_byte[3]), .i_TX_DV(dv[3]),
    .o_TX_Ready(ready[3]), .o_RX_DV(rx_dv[3]), .o_RX_Byte(rx_byte[3]),
    .o_SPI_Clk(sclk[3]), .i_SPI_MISO(miso[3]), .o_SPI_MOSI(mosi[3]));

  typedef struct {
    int         inst;
    logic [7:0] tx;
    logic       lp;
    logic [7:0] sl;
    logic [7:0] exp_rx;
    logic [7:0] exp_seen;
  } vec_t;

  vec_t vecs [8];

  // Instance i runs SPI mode i; these mirror the mode definitions, not the RTL.
  function automatic logic cpol_of(input int m);
    return (m == 2) || (m == 3);
  endfunction

  function automatic logic cpha_of(input int m);
    return (m == 1) || (m == 3);
  endfunction

  function automatic int nhb_of(input int m);
    case (m)
      0:       return 3;
      3:       return 4;
      default: return 2;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One full transfer on instance m, watched cycle by cycle at the falling
  // clock edge; a behavioural slave answers with sl when loopback is off.
  task automatic apply_stimulus(input int m, input logic [7:0] b, input logic lp,
                                input logic [7:0] sl, input logic [7:0] exp_rx,
                                input logic [7:0] exp_seen, input int dv_at,
                                input string tag);
    int         wait_cyc;
    int         low;
    int         edges;
    int         sidx;
    int         dv_hits;
    int         hold_errs;
    int         stab_errs;
    logic       prev_sclk;
    logic       prev_mosi;
    logic       leading;
    logic [7:0] seen;
    logic [7:0] rx_prev;
    wait_cyc = 0;
    while (ready[m] !== 1'b1 && wait_cyc < 200) begin
      @(negedge clk);
      wait_cyc++;
    end
    check_output({tag, "_start_ready"}, 32'(ready[m]), 32'd1);
    check_output({tag, "_idle_sclk"}, 32'(sclk[m]), 32'(cpol_of(m)));
    loop_en[m] = lp;
    sidx = 7;
    if (!cpha_of(m)) begin
      slave_miso[m] = sl[7];
      sidx = 6;
    end
    rx_prev    = rx_byte[m];
    tx_byte[m] = b;
    dv[m]      = 1'b1;
    @(negedge clk);
    dv[m]     = 1'b0;
    low       = 0;
    edges     = 0;
    dv_hits   = 0;
    hold_errs = 0;
    stab_errs = 0;
    seen      = 8'h00;
    prev_sclk = sclk[m];
    prev_mosi = mosi[m];
    while (ready[m] === 1'b0 && low < 300) begin
      low++;
      if (rx_dv[m] !== 1'b0) dv_hits++;
      if (rx_byte[m] !== rx_prev) hold_errs++;
      if (sclk[m] !== prev_sclk) begin
        edges++;
        leading = edges[0];
        if (cpha_of(m) ? !leading : leading) begin
          if (mosi[m] !== prev_mosi) stab_errs++;
          seen = {seen[6:0], mosi[m]};
        end
        if (!lp && sidx >= 0 && (cpha_of(m) ? leading : (!leading && edges < 16))) begin
          slave_miso[m] = sl[sidx];
          sidx--;
        end
      end
      if (low == dv_at) begin
        tx_byte[m] = 8'h00;
        dv[m]      = 1'b1;
      end else begin
        dv[m] = 1'b0;
      end
      prev_sclk = sclk[m];
      prev_mosi = mosi[m];
      @(negedge clk);
    end
    dv[m] = 1'b0;
    check_output({tag, "_busy_cycles"}, 32'(low), 32'(16 * nhb_of(m) + 1));
    check_output({tag, "_sclk_edges"}, 32'(edges), 32'd16);
    check_output({tag, "_early_rx_dv"}, 32'(dv_hits), 32'd0);
    check_output({tag, "_rx_byte_hold"}, 32'(hold_errs), 32'd0);
    check_output({tag, "_mosi_stable"}, 32'(stab_errs), 32'd0);
    check_output({tag, "_slave_seen"}, 32'(seen), 32'(exp_seen));
    check_output({tag, "_rx_dv"}, 32'(rx_dv[m]), 32'd1);
    check_output({tag, "_rx_byte"}, 32'(rx_byte[m]), 32'(exp_rx));
    check_output({tag, "_end_sclk"}, 32'(sclk[m]), 32'(cpol_of(m)));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int         edges;
    int         w;
    logic       prev;
    int         m;
    logic [7:0] b;
    logic [7:0] sl;
    logic       lp;

    vecs[0] = '{0, 8'hA5, 1'b1, 8'h00, 8'hA5, 8'hA5};
    vecs[1] = '{3, 8'hFF, 1'b0, 8'h3C, 8'h3C, 8'hFF};
    vecs[2] = '{1, 8'h81, 1'b1, 8'h00, 8'h81, 8'h81};
    vecs[3] = '{2, 8'h81, 1'b1, 8'h00, 8'h81, 8'h81};
    vecs[4] = '{3, 8'h5A, 1'b1, 8'h00, 8'h5A, 8'h5A};
    vecs[5] = '{0, 8'h00, 1'b0, 8'hC3, 8'hC3, 8'h00};
    vecs[6] = '{1, 8'h7E, 1'b0, 8'h18, 8'h18, 8'h7E};
    vecs[7] = '{2, 8'h01, 1'b0, 8'h80, 8'h80, 8'h01};

    for (int i = 0; i < 4; i++) begin
      rst[i]        = 1'b1;
      dv[i]         = 1'b0;
      tx_byte[i]    = 8'h00;
      loop_en[i]    = 1'b1;
      slave_miso[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("rst%0d_ready", i), 32'(ready[i]), 32'd1);
      check_output($sformatf("rst%0d_sclk", i), 32'(sclk[i]), 32'(cpol_of(i)));
      check_output($sformatf("rst%0d_rx_dv", i), 32'(rx_dv[i]), 32'd0);
      check_output($sformatf("rst%0d_rx_byte", i), 32'(rx_byte[i]), 32'd0);
      check_output($sformatf("rst%0d_mosi", i), 32'(mosi[i]), 32'd0);
    end

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].inst, vecs[i].tx, vecs[i].lp, vecs[i].sl,
                     vecs[i].exp_rx, vecs[i].exp_seen, -1, $sformatf("vec%0d", i));
    end

    apply_stimulus(0, 8'h6C, 1'b1, 8'h00, 8'h6C, 8'h6C, 20, "ignored_dv");
    apply_stimulus(0, 8'h12, 1'b1, 8'h00, 8'h12, 8'h12, -1, "b2b_first");
    apply_stimulus(0, 8'h34, 1'b1, 8'h00, 8'h34, 8'h34, -1, "b2b_second");
    @(negedge clk);
    check_output("b2b_rx_dv_single", 32'(rx_dv[0]), 32'd0);

    loop_en[2] = 1'b1;
    w = 0;
    while (ready[2] !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    tx_byte[2] = 8'hF7;
    dv[2]      = 1'b1;
    @(negedge clk);
    dv[2] = 1'b0;
    edges = 0;
    w     = 0;
    prev  = sclk[2];
    while (edges < 5 && w < 200) begin
      @(negedge clk);
      w++;
      if (sclk[2] !== prev) begin
        edges++;
        prev = sclk[2];
      end
    end
    check_output("mid_rst_reached_edge5", 32'(edges), 32'd5);
    rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    check_output("mid_rst_sclk", 32'(sclk[2]), 32'(cpol_of(2)));
    check_output("mid_rst_ready", 32'(ready[2]), 32'd1);
    check_output("mid_rst_mosi", 32'(mosi[2]), 32'd0);
    check_output("mid_rst_rx_dv", 32'(rx_dv[2]), 32'd0);
    @(negedge clk);
    check_output("mid_rst_after_rx_dv", 32'(rx_dv[2]), 32'd0);
    check_output("mid_rst_after_rx_byte", 32'(rx_byte[2]), 32'd0);
    apply_stimulus(2, 8'h5A, 1'b1, 8'h00, 8'h5A, 8'h5A, -1, "mid_rst_next");

    for (int i = 0; i < 24; i++) begin
      m  = int'($urandom_range(0, 3));
      b  = 8'($urandom);
      sl = 8'($urandom);
      lp = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      apply_stimulus(m, b, lp, sl, lp ? b : sl, b, -1, $sformatf("rnd%0d", i));
    end

    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("final%0d_rx_dv", i), 32'(rx_dv[i]), 32'd0);
      check_output($sformatf("final%0d_ready", i), 32'(ready[i]), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-byte, full-duplex SPI master engine, MSB first.
- It serialises one byte on MOSI while capturing one byte from MISO, then signals ready for the next byte.
- It sits under higher-level sequencers, for example the SPI flash loader that drives chip-select and byte framing itself.
- Chip-select is not generated here.

Parameters:
- SPI_MODE, 0, SPI mode 0..3. CPOL = (mode==2 || mode==3); CPHA = (mode==1 || mode==3).
- CLKS_PER_HALF_BIT, 2, number of i_Clk cycles per SCLK half-period. Must be >=2.

Ports:
- i_Clk  input  1  system clock; all logic on its rising edge.
- i_Rst  input  1  synchronous, active-high reset.
- i_TX_Byte  input  8  byte to transmit; latched when i_TX_DV is accepted.
- i_TX_DV  input  1  one-cycle start pulse.
- o_TX_Ready  output  1  high when idle and able to accept i_TX_DV.
- o_RX_DV  output  1  one-cycle pulse; o_RX_Byte is valid.
- o_RX_Byte  output  8  last received byte; holds until the next o_RX_DV.
- o_SPI_Clk  output  1  SCLK.
- i_SPI_MISO  input  1  serial data in.
- o_SPI_MOSI  output  1  serial data out.

Behaviour:
- Reset (any time, including mid-transfer; the transfer is aborted):
  - o_TX_Ready=1, o_RX_DV=0, o_RX_Byte=0x00, o_SPI_Clk=CPOL, o_SPI_MOSI=0.
  - Edge counter and bit indices cleared.
- Idle:
  - o_SPI_Clk=CPOL.
  - MOSI holds its last driven value.
- Start:
  - On a rising edge T0 with i_TX_DV=1 and o_TX_Ready=1: latch i_TX_Byte, drive o_TX_Ready=0, load the edge count to 16.
  - i_TX_DV while o_TX_Ready=0 is ignored; no queueing.
- SCLK generation:
  - A half-bit counter runs during the transfer.
  - SCLK toggles every CLKS_PER_HALF_BIT cycles.
  - The first toggle (leading edge) lands at T0+CLKS_PER_HALF_BIT. Edge k (1..16) lands at T0+k*CLKS_PER_HALF_BIT.
  - Odd edges are leading (away from CPOL); even edges are trailing (back to CPOL).
  - After edge 16, SCLK rests at CPOL.
- MOSI timing:
  - CPHA=0: bit7 is driven at T0+1, before the first edge. Bits 6..0 are driven on trailing edges 2,4,...,14.
  - CPHA=1: bits 7..0 are driven on leading edges 1,3,...,15.
- MISO sampling:
  - CPHA=0: sample on leading edges 1,3,...,15.
  - CPHA=1: sample on trailing edges 2,4,...,16.
  - i_SPI_MISO is captured on the same i_Clk edge that toggles SCLK.
  - Captured bits shift into the receive register MSB first.
- Completion:
  - At T0+16*CLKS_PER_HALF_BIT+1, o_TX_Ready returns to 1.
  - On that same cycle o_RX_DV pulses high for exactly one cycle, with o_RX_Byte updated to the full received byte.
  - A new i_TX_DV is accepted on that cycle or any later cycle.
  - Back-to-back transfers incur no extra idle SCLK edges beyond the restart latency.
- o_RX_DV is never high for more than one cycle.
- o_RX_Byte changes only together with o_RX_DV, or on reset.
- Transfer length, from DV accepted to ready: exactly 16*CLKS_PER_HALF_BIT+1 cycles.
- All outputs are registered; no combinational paths from inputs to outputs.

Test Plan:
- Reset and idle:
  - Stimulus: assert i_Rst 2 cycles in each of modes 0 and 3.
  - Required: o_TX_Ready=1, o_SPI_Clk=0 (mode 0) or 1 (mode 3), o_RX_DV=0, o_RX_Byte=0x00.
- Mode 0 loopback:
  - Stimulus: CLKS_PER_HALF_BIT=3, MISO tied to MOSI, send 0xA5.
  - Required: exactly 8 SCLK pulses; MOSI stable around each rising edge reading 1,0,1,0,0,1,0,1; o_TX_Ready low for 49 cycles; one o_RX_DV pulse with o_RX_Byte=0xA5.
- Mode 3 with external slave model:
  - Stimulus: slave returns 0x3C on MISO; master sends 0xFF.
  - Required: SCLK idles high; MISO captured on rising (trailing) edges; o_RX_Byte=0x3C; the slave observes 0xFF.
- Modes 1 and 2:
  - Stimulus: send 0x81 with loopback in each mode.
  - Required: o_RX_Byte=0x81; SCLK idle level matches CPOL; 16 edges total.
- Ignored DV and back-to-back:
  - Stimulus: pulse i_TX_DV mid-transfer with 0x00, then issue 0x12 and 0x34 each on the ready cycle.
  - Required: the mid-transfer pulse has no effect; two o_RX_DV pulses with loopback values 0x12 then 0x34.
- Reset mid-transfer:
  - Stimulus: assert i_Rst after the 5th SCLK edge.
  - Required: next cycle o_SPI_Clk=CPOL, o_TX_Ready=1, o_SPI_MOSI=0, no o_RX_DV; a following transfer of 0x5A completes with o_RX_Byte=0x5A.
